// File: rtl/ahblite_lcd_8080.sv
// ahblite_lcd_8080: AHB-Lite slave driving an 8080-style parallel LCD bus.
// Firmware pushes command/pixel words into a small FIFO; a strobe FSM replays
// each word on the panel pins using programmable setup, WR-low and hold times.
// FIFO_DEPTH must be 2, 4 or 8 so the pointers wrap naturally.
module ahblite_lcd_8080 #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        LCD_CS,
  output logic        LCD_RS,
  output logic        LCD_WR,
  output logic        LCD_RD,
  output logic        LCD_RST,
  output logic        LCD_BL_CTR,
  output logic [15:0] LCD_DATA
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  // Registered address phase
  logic        dp_valid;
  logic        dp_write;
  logic [1:0]  dp_addr;

  // Control register, stored with unimplemented bits already zeroed
  logic [15:0] ctrl_reg;

  // Word FIFO
  logic [16:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          ctrl_we;

  // Strobe engine
  state_t      state;
  state_t      state_next;
  logic [3:0]  phase_cnt;
  logic [3:0]  phase_next;
  logic [3:0]  setup_q;
  logic [3:0]  wrlow_q;
  logic [3:0]  hold_q;
  logic        rs_q;
  logic [15:0] data_q;

  logic [3:0]  count4;
  logic        unused_ok;

  assign unused_ok = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE, HPROT, HWDATA[31:16]};

  assign fifo_full  = (fifo_count == DEPTH_C);
  assign fifo_empty = (fifo_count == '0);
  assign push_req   = dp_valid & dp_write & ~dp_addr[1];
  assign push       = push_req & (~fifo_full | pop);
  assign ctrl_we    = dp_valid & dp_write & (dp_addr == 2'b10);
  assign HREADYOUT  = ~(push_req & fifo_full & ~pop);
  assign HRESP      = 1'b0;
  assign count4     = 4'(fifo_count);

  // Capture the address phase; hold it while a stalled push waits for a slot
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 2'b00;
    end else if (HREADY) begin
      dp_valid <= HSEL & HTRANS[1];
      dp_write <= HWRITE;
      dp_addr  <= HADDR[3:2];
    end
  end

  // CTRL register write; pins follow from the register on the next cycle
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ctrl_reg <= 16'h1110;
    end else if (ctrl_we) begin
      ctrl_reg <= HWDATA[15:0] & 16'hFFF3;
    end
  end

  // Zero-wait read mux driven from the registered address
  always_comb begin
    HRDATA = 32'h0;
    if (dp_valid && !dp_write) begin
      case (dp_addr)
        2'b10:   HRDATA = {16'h0, ctrl_reg};
        2'b11:   HRDATA = {20'h0, count4, 5'b0, fifo_empty, fifo_full, (state != ST_IDLE)};
        default: HRDATA = 32'h0;
      endcase
    end
  end

  // FIFO storage has no reset; emptiness is carried by the count
  always_ff @(posedge HCLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {~dp_addr[0] ? 1'b0 : 1'b1, HWDATA[15:0]};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count alone
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Strobe FSM state and phase counter register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      phase_cnt <= 4'd0;
    end else begin
      state     <= state_next;
      phase_cnt <= phase_next;
    end
  end

  // Next-state logic; each phase lasts its field value plus one cycle
  always_comb begin
    state_next = state;
    phase_next = phase_cnt + 4'd1;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        phase_next = 4'd0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (phase_cnt == setup_q) begin
          phase_next = 4'd0;
          state_next = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (phase_cnt == wrlow_q) begin
          phase_next = 4'd0;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (phase_cnt == hold_q) begin
          phase_next = 4'd0;
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = ST_SETUP;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        phase_next = 4'd0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // Latch the popped word and the timing in force at pop time
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rs_q    <= 1'b0;
      data_q  <= 16'h0;
      setup_q <= 4'd1;
      wrlow_q <= 4'd1;
      hold_q  <= 4'd1;
    end else if (pop) begin
      rs_q    <= fifo_mem[rd_ptr][16];
      data_q  <= fifo_mem[rd_ptr][15:0];
      setup_q <= ctrl_reg[7:4];
      wrlow_q <= ctrl_reg[11:8];
      hold_q  <= ctrl_reg[15:12];
    end
  end

  assign LCD_CS     = (state == ST_IDLE);
  assign LCD_WR     = (state != ST_STROBE);
  assign LCD_RD     = 1'b1;
  assign LCD_RS     = rs_q;
  assign LCD_DATA   = data_q;
  assign LCD_RST    = ctrl_reg[0];
  assign LCD_BL_CTR = ctrl_reg[1];

endmodule
